// File: rtl/micro86_bus_if.sv
// Bus bundle between the micro86 bridge and its CPU/BRAM/external neighbours.
// The slave modport is the bridge's view; the master modport is everything around it.
interface micro86_bus_if #(
  parameter int BRAM_BITS = 16
);
  logic [19:0]          cpu_a;
  logic [7:0]           cpu_o;
  logic                 cpu_w;
  logic [7:0]           cpu_i;
  logic                 cpu_ce;
  logic [BRAM_BITS-1:0] bram_a;
  logic [7:0]           bram_d;
  logic                 bram_we;
  logic [7:0]           bram_q;
  logic [19:0]          ext_addr;
  logic [7:0]           ext_wdata;
  logic                 ext_we;
  logic                 ext_req;
  logic                 ext_ack;
  logic [7:0]           ext_rdata;
  logic                 bus_err;

  modport slave (
    input  cpu_a, cpu_o, cpu_w, bram_q, ext_ack, ext_rdata,
    output cpu_i, cpu_ce, bram_a, bram_d, bram_we,
           ext_addr, ext_wdata, ext_we, ext_req, bus_err
  );

  modport master (
    output cpu_a, cpu_o, cpu_w, bram_q, ext_ack, ext_rdata,
    input  cpu_i, cpu_ce, bram_a, bram_d, bram_we,
           ext_addr, ext_wdata, ext_we, ext_req, bus_err
  );
endinterface

// File: rtl/micro86_bus.sv
// micro86 memory bridge: latches a CPU cycle, serves it from BRAM or the external
// req/ack port (with timeout), then pulses cpu_ce once to let the core advance.
module micro86_bus #(
  parameter int BRAM_BITS = 16,
  parameter int TIMEOUT   = 255
) (
  input logic         clock,
  input logic         reset,
  micro86_bus_if.slave bus
);
  typedef enum logic [1:0] {S_ADDR, S_LAT, S_EXT, S_CE} state_e;

  state_e               state_q, state_d;
  logic                 w_q, w_d;
  logic [7:0]           cpu_i_q, cpu_i_d;
  logic [BRAM_BITS-1:0] bram_a_q, bram_a_d;
  logic [7:0]           bram_d_q, bram_d_d;
  logic                 bram_we_q, bram_we_d;
  logic [19:0]          ext_addr_q, ext_addr_d;
  logic [7:0]           ext_wdata_q, ext_wdata_d;
  logic                 ext_we_q, ext_we_d;
  logic                 ext_req_q, ext_req_d;
  logic                 bus_err_q, bus_err_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 is_bram;
  logic                 tmo;
  logic                 cpu_ce;

  // Shift form keeps the decode legal for any BRAM_BITS below 20.
  assign is_bram = ((bus.cpu_a >> BRAM_BITS) == 20'd0);
  // Counter is 0 in the first S_EXT cycle, so this fires in S_EXT cycle TIMEOUT.
  assign tmo     = (cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_ADDR;
      w_q         <= 1'b0;
      cpu_i_q     <= 8'h00;
      bram_a_q    <= '0;
      bram_d_q    <= 8'h00;
      bram_we_q   <= 1'b0;
      ext_addr_q  <= 20'h0;
      ext_wdata_q <= 8'h00;
      ext_we_q    <= 1'b0;
      ext_req_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      cnt_q       <= 16'h0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      cpu_i_q     <= cpu_i_d;
      bram_a_q    <= bram_a_d;
      bram_d_q    <= bram_d_d;
      bram_we_q   <= bram_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ext_we_q    <= ext_we_d;
      ext_req_q   <= ext_req_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ADDR:  state_d = is_bram ? S_LAT : S_EXT;
      S_LAT:   state_d = S_CE;
      S_EXT:   if (bus.ext_ack || tmo) state_d = S_CE;
      default: state_d = S_ADDR;
    endcase
  end

  always_comb begin
    w_d         = w_q;
    cpu_i_d     = cpu_i_q;
    bram_a_d    = bram_a_q;
    bram_d_d    = bram_d_q;
    bram_we_d   = 1'b0;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ext_we_d    = ext_we_q;
    ext_req_d   = ext_req_q;
    bus_err_d   = bus_err_q;
    cnt_d       = cnt_q;
    cpu_ce      = 1'b0;
    unique case (state_q)
      S_ADDR: begin
        w_d = bus.cpu_w;
        if (is_bram) begin
          bram_a_d  = bus.cpu_a[BRAM_BITS-1:0];
          bram_d_d  = bus.cpu_o;
          bram_we_d = bus.cpu_w;
        end else begin
          ext_addr_d  = bus.cpu_a;
          ext_wdata_d = bus.cpu_o;
          ext_we_d    = bus.cpu_w;
          ext_req_d   = 1'b1;
          cnt_d       = 16'h0;
        end
      end
      S_LAT: if (!w_q) cpu_i_d = bus.bram_q;
      S_EXT: begin
        cnt_d = cnt_q + 16'd1;
        // Ack takes priority over a coincident timeout.
        if (bus.ext_ack) begin
          ext_req_d = 1'b0;
          if (!ext_we_q) cpu_i_d = bus.ext_rdata;
        end else if (tmo) begin
          ext_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!ext_we_q) cpu_i_d = 8'hFF;
        end
      end
      default: cpu_ce = 1'b1;
    endcase
  end

  assign bus.cpu_i     = cpu_i_q;
  assign bus.cpu_ce    = cpu_ce;
  assign bus.bram_a    = bram_a_q;
  assign bus.bram_d    = bram_d_q;
  assign bus.bram_we   = bram_we_q;
  assign bus.ext_addr  = ext_addr_q;
  assign bus.ext_wdata = ext_wdata_q;
  assign bus.ext_we    = ext_we_q;
  assign bus.ext_req   = ext_req_q;
  assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_micro86_bus.sv
// Bench for micro86_bus: stimulus pushes expected completions into a queue and a
// negedge monitor pops one per cpu_ce; per-cycle bus protocol is checked in-line.
module tb_micro86_bus;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  micro86_bus_if #(.BRAM_BITS(16)) bus ();
  micro86_bus #(.BRAM_BITS(16), .TIMEOUT(T)) dut (.clock(clk), .reset(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: registered address from the bridge, data visible in the same cycle.
  logic [7:0]  bram [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_a  = 16'h0;
  logic [7:0]  pl_d  = 8'h0;
  always @(posedge clk)
    if (pl_en) bram[pl_a] <= pl_d;
    else if (bus.bram_we) bram[bus.bram_a] <= bus.bram_d;
  assign bus.bram_q = bram[bus.bram_a];

  // External responder: acks in the cur_dly-th cycle of ext_req, or once at late_ack.
  int cur_dly  = 0;
  int late_ack = -1;
  int req_cyc  = 0;
  initial begin
    bus.ext_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (bus.ext_req) req_cyc++; else req_cyc = 0;
      bus.ext_ack = (bus.ext_req && req_cyc == cur_dly) || (cyc == late_ack);
    end
  end

  typedef struct { logic [7:0] data; int ce_cyc; logic err; } exp_t;
  exp_t        sb[$];
  logic [7:0]  ref_mem [int];
  logic [19:0] known[$];
  logic [7:0]  last_i = 8'h00;
  logic        err_m  = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          last_ce = -10;
  logic        b2b = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.cpu_ce) begin
        check("ce_gap", 32'(cyc - last_ce > 1), 32'd1);
        if (b2b) check("ce_period", 32'(cyc - last_ce), 32'd3);
        last_ce = cyc;
        if (sb.size() == 0) check("unexpected_ce", 32'(bus.cpu_ce), 32'd0);
        else begin
          e = sb.pop_front();
          check("ce_cycle", 32'(cyc), 32'(e.ce_cyc));
          check("cpu_i", 32'(bus.cpu_i), 32'(e.data));
          check("bus_err", 32'(bus.bus_err), 32'(e.err));
        end
      end
    end
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    ref_mem[int'(a)] = d;
    known.push_back({4'h0, a});
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Called at the start of an S_ADDR cycle; returns at the start of the next one.
  task automatic issue(input logic [19:0] a, input logic [7:0] o, input logic w,
                       input int d, input logic [7:0] rdat, output logic [7:0] rd);
    bit   br;
    int   lat;
    int   req_n;
    exp_t e;
    rd = 8'h00;
    br = (a[19:16] == 4'h0);
    bus.cpu_a = a; bus.cpu_o = o; bus.cpu_w = w;
    bus.ext_rdata = rdat; cur_dly = d;
    if (br) begin
      lat = 2;
      if (w) begin ref_mem[int'(a)] = o; known.push_back(a); end
      else last_i = ref_mem[int'(a)];
    end else if (d <= T) begin
      lat = d + 1;
      if (!w) last_i = rdat;
    end else begin
      lat = T + 1;
      if (!w) last_i = 8'hFF;
      err_m = 1'b1;
    end
    req_n = lat - 1;
    e.data = last_i; e.ce_cyc = cyc + lat; e.err = err_m;
    sb.push_back(e);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (br) begin
        check("bram_we", 32'(bus.bram_we), 32'((c == 1) && w));
        if (c == 1) begin
          check("bram_a", 32'(bus.bram_a), 32'(a[15:0]));
          if (w) check("bram_d", 32'(bus.bram_d), 32'(o));
        end
        check("no_ext_req", 32'(bus.ext_req), 32'd0);
      end else begin
        check("ext_req", 32'(bus.ext_req), 32'(c <= req_n));
        if (c <= req_n) begin
          check("ext_addr", 32'(bus.ext_addr), 32'(a));
          check("ext_we", 32'(bus.ext_we), 32'(w));
          if (w) check("ext_wdata", 32'(bus.ext_wdata), 32'(o));
        end
        check("no_bram_we", 32'(bus.bram_we), 32'd0);
      end
      if (bus.cpu_ce) begin rd = bus.cpu_i; break; end
      if (c == 40) check("ce_wait", 32'(bus.cpu_ce), 32'd1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] rd, op, imm, al;
    int kind;
    bus.cpu_a = 20'h0; bus.cpu_o = 8'h0; bus.cpu_w = 1'b0; bus.ext_rdata = 8'h0;
    @(posedge clk); #1;
    preload(16'h0010, 8'hA5);
    preload(16'hFFFF, 8'h6E);
    for (int k = 0; k < 4; k++) begin
      preload(16'h0100 + 16'(2*k), 8'h04);
      preload(16'h0101 + 16'(2*k), 8'h05);
    end
    for (int k = 0; k < 6; k++) preload(16'($urandom), 8'($urandom));
    check("rst_cpu_ce", 32'(bus.cpu_ce), 32'd0);
    check("rst_cpu_i", 32'(bus.cpu_i), 32'd0);
    check("rst_bram_we", 32'(bus.bram_we), 32'd0);
    check("rst_ext_req", 32'(bus.ext_req), 32'd0);
    check("rst_bus_err", 32'(bus.bus_err), 32'd0);
    rst = 1'b0;

    issue(20'h00010, 8'h00, 1'b0, 0, 8'h00, rd);
    check("bram_rd_a5", 32'(rd), 32'hA5);
    issue(20'h01234, 8'h5A, 1'b1, 0, 8'h00, rd);
    issue(20'h01234, 8'h00, 1'b0, 0, 8'h00, rd);
    check("bram_rd_5a", 32'(rd), 32'h5A);
    issue(20'h10000, 8'h00, 1'b0, 4, 8'h3C, rd);
    check("ext_rd_3c", 32'(rd), 32'h3C);
    issue(20'h0FFFF, 8'h00, 1'b0, 0, 8'h00, rd);
    issue(20'hB8000, 8'h00, 1'b0, T, 8'h77, rd);
    issue(20'hB8000, 8'h00, 1'b0, 99, 8'h11, rd);
    issue(20'h00010, 8'h00, 1'b0, 0, 8'h00, rd);

    // External read aborted by reset in its third cycle.
    bus.cpu_a = 20'hC0000; bus.cpu_w = 1'b0; cur_dly = 50;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_req_up", 32'(bus.ext_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ext_req", 32'(bus.ext_req), 32'd0);
    check("abort_cpu_ce", 32'(bus.cpu_ce), 32'd0);
    check("abort_cpu_i", 32'(bus.cpu_i), 32'd0);
    check("abort_bram_a", 32'(bus.bram_a), 32'd0);
    check("abort_ext_addr", 32'(bus.ext_addr), 32'd0);
    check("abort_bus_err", 32'(bus.bus_err), 32'd0);
    rst = 1'b0; last_i = 8'h00; err_m = 1'b0; late_ack = cyc + 1;
    issue(20'h0FFFF, 8'h00, 1'b0, 0, 8'h00, rd);

    // Tiny core model running ADD AL,5 four times out of BRAM.
    al = 8'h00;
    for (int k = 0; k < 4; k++) begin
      issue(20'h00100 + 20'(2*k), 8'h00, 1'b0, 0, 8'h00, op);
      b2b = 1'b1;
      issue(20'h00101 + 20'(2*k), 8'h00, 1'b0, 0, 8'h00, imm);
      if (op == 8'h04) al = al + imm;
    end
    b2b = 1'b0;
    check("al_after_prog", 32'(al), 32'd20);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 0)
        issue(known[$urandom_range(0, known.size() - 1)], 8'($urandom), 1'b0, 0, 8'h00, rd);
      else if (kind == 1)
        issue({4'h0, 16'($urandom)}, 8'($urandom), 1'b1, 0, 8'h00, rd);
      else
        issue({4'($urandom_range(1, 15)), 16'($urandom)}, 8'($urandom), 1'($urandom),
              int'($urandom_range(1, 10)), 8'($urandom), rd);
    end
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
